// File: rtl/bcd_to_seg_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : bcd_to_seg_reg                                           |
// | Description : Registered hex-to-seven-segment decoder with blanking,   |
// |               lamp-test and decimal-point control. One cycle latency.  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module bcd_to_seg_reg #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] BCD,
  input  logic       blank,
  input  logic       lamp_test,
  input  logic       dp_in,
  output logic [6:0] seg,
  output logic       dp
);

  // Segment order throughout is abcdefg, a in the MSB.
  localparam logic [6:0] SEG_ALL_ON  = 7'b1111111;
  localparam logic [6:0] SEG_ALL_OFF = 7'b0000000;

  // "Off" level seen on the pins, after optional inversion.
  localparam logic [6:0] SEG_OFF_PIN = ACTIVE_LOW ? SEG_ALL_ON : SEG_ALL_OFF;
  localparam logic       DP_OFF_PIN  = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [6:0] glyph;
  logic [6:0] seg_prio;
  logic       dp_prio;
  logic [6:0] seg_next;
  logic       dp_next;

  // Active-high glyph lookup; every 4-bit code has a defined pattern.
  always_comb begin
    glyph = SEG_ALL_OFF;
    case (BCD)
      4'h0: glyph = 7'b1111110;
      4'h1: glyph = 7'b0110000;
      4'h2: glyph = 7'b1101101;
      4'h3: glyph = 7'b1111001;
      4'h4: glyph = 7'b0110011;
      4'h5: glyph = 7'b1011011;
      4'h6: glyph = 7'b1011111;
      4'h7: glyph = 7'b1110000;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1111011;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b0011111;
      4'hC: glyph = 7'b1001110;
      4'hD: glyph = 7'b0111101;
      4'hE: glyph = 7'b1001111;
      4'hF: glyph = 7'b1000111;
      default: glyph = SEG_ALL_OFF;
    endcase
  end

  // Resolve lamp-test over blank over normal decode, still active-high.
  always_comb begin
    seg_prio = glyph;
    dp_prio  = dp_in;
    if (lamp_test) begin
      seg_prio = SEG_ALL_ON;
      dp_prio  = 1'b1;
    end else if (blank) begin
      seg_prio = SEG_ALL_OFF;
      dp_prio  = 1'b0;
    end
  end

  // Apply display polarity after priority so control levels invert too.
  always_comb begin
    seg_next = ACTIVE_LOW ? ~seg_prio : seg_prio;
    dp_next  = ACTIVE_LOW ? ~dp_prio  : dp_prio;
  end

  // Single output register: async reset to the off level, load when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_OFF_PIN;
      dp  <= DP_OFF_PIN;
    end else if (en) begin
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_seg_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_bcd_to_seg_reg                                        |
// | Description : Directed self-checking bench for bcd_to_seg_reg, driving |
// |               an active-high and an active-low instance in parallel.   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_bcd_to_seg_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] BCD;
  logic       blank;
  logic       lamp_test;
  logic       dp_in;
  logic [6:0] seg_hi;
  logic       dp_hi;
  logic [6:0] seg_lo;
  logic       dp_lo;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Hand-written active-high abcdefg patterns for codes 0..F.
  logic [6:0] glyph_tbl [16];

  always #5 clk = ~clk;

  bcd_to_seg_reg #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .BCD(BCD), .blank(blank),
    .lamp_test(lamp_test), .dp_in(dp_in), .seg(seg_hi), .dp(dp_hi)
  );

  bcd_to_seg_reg #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .BCD(BCD), .blank(blank),
    .lamp_test(lamp_test), .dp_in(dp_in), .seg(seg_lo), .dp(dp_lo)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare both instances against one active-high expectation {seg,dp};
  // the active-low instance must show the bitwise complement.
  task automatic check(input string tag, input logic [6:0] exp_seg, input logic exp_dp);
    total_cnt++;
    assert ({seg_hi, dp_hi} === {exp_seg, exp_dp}) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s hi: seg=%b dp=%b expected seg=%b dp=%b", tag, seg_hi, dp_hi, exp_seg, exp_dp);
    end
    total_cnt++;
    assert ({seg_lo, dp_lo} === {~exp_seg, ~exp_dp}) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s lo: seg=%b dp=%b expected seg=%b dp=%b", tag, seg_lo, dp_lo, ~exp_seg, ~exp_dp);
    end
  endtask

  initial begin
    glyph_tbl[0]  = 7'b1111110; glyph_tbl[1]  = 7'b0110000;
    glyph_tbl[2]  = 7'b1101101; glyph_tbl[3]  = 7'b1111001;
    glyph_tbl[4]  = 7'b0110011; glyph_tbl[5]  = 7'b1011011;
    glyph_tbl[6]  = 7'b1011111; glyph_tbl[7]  = 7'b1110000;
    glyph_tbl[8]  = 7'b1111111; glyph_tbl[9]  = 7'b1111011;
    glyph_tbl[10] = 7'b1110111; glyph_tbl[11] = 7'b0011111;
    glyph_tbl[12] = 7'b1001110; glyph_tbl[13] = 7'b0111101;
    glyph_tbl[14] = 7'b1001111; glyph_tbl[15] = 7'b1000111;

    // Reset with lamp-test requested, before any clock edge.
    rst_n = 1'b1; en = 1'b1; BCD = 4'd8; blank = 1'b0;
    lamp_test = 1'b1; dp_in = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("reset_async", 7'b0000000, 1'b0);
    tick();
    tick();
    check("reset_hold", 7'b0000000, 1'b0);
    #2 rst_n = 1'b1;
    #1 check("reset_release", 7'b0000000, 1'b0);
    tick();
    check("first_edge_lamp", 7'b1111111, 1'b1);

    // Full sweep of all 16 codes.
    lamp_test = 1'b0;
    for (int i = 0; i < 16; i++) begin
      BCD = 4'(i);
      tick();
      check($sformatf("sweep_%0d", i), glyph_tbl[i], 1'b0);
    end

    // Enable hold.
    BCD = 4'd3;
    tick();
    check("load_3", 7'b1111001, 1'b0);
    en = 1'b0; BCD = 4'd7; dp_in = 1'b1;
    tick();
    check("hold_1", 7'b1111001, 1'b0);
    tick();
    check("hold_2", 7'b1111001, 1'b0);
    en = 1'b1;
    tick();
    check("resume_7", 7'b1110000, 1'b1);

    // Control priority.
    BCD = 4'd2; dp_in = 1'b1; blank = 1'b1;
    tick();
    check("blank", 7'b0000000, 1'b0);
    lamp_test = 1'b1;
    tick();
    check("lamp_over_blank", 7'b1111111, 1'b1);
    lamp_test = 1'b0; blank = 1'b0;
    tick();
    check("decode_2_dp", 7'b1101101, 1'b1);

    // Active-low spot values (low instance sees seg=1001111 dp=1, then 0110001).
    BCD = 4'd1; dp_in = 1'b0;
    tick();
    check("code_1", 7'b0110000, 1'b0);
    BCD = 4'hC;
    tick();
    check("code_C", 7'b1001110, 1'b0);

    // Async reset pulse mid-count, between edges.
    BCD = 4'd4;
    tick();
    BCD = 4'd5;
    tick();
    check("count_5", 7'b1011011, 1'b0);
    BCD = 4'd6;
    #2 rst_n = 1'b0;
    #1 check("mid_reset", 7'b0000000, 1'b0);
    #1 rst_n = 1'b1;
    #1 check("mid_release", 7'b0000000, 1'b0);
    tick();
    check("resume_6", 7'b1011111, 1'b0);
    BCD = 4'd9;
    tick();
    check("resume_9", 7'b1111011, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_to_seg_reg.md
Name: bcd_to_seg_reg

Overview:
- Registered hexadecimal-to-seven-segment decoder for the frequency counter display path.
- Converts a 4-bit code (0-9 plus A-F) into seven segment drive lines a..g.
- Adds blanking, lamp-test and decimal-point control.
- Output is registered: one clock of latency, glitch-free drive to the display.

Parameters:
- ACTIVE_LOW, 0, 1 = segment and dp outputs inverted for common-anode displays; 0 = active-high (common-cathode).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- en  input  1  load enable; when 0 the outputs hold their value
- BCD  input  4  code to display, 0x0-0xF
- blank  input  1  force all segments and dp off
- lamp_test  input  1  force all segments and dp on
- dp_in  input  1  decimal point request
- seg  output  7  segment drive, seg[6]=a, seg[5]=b, seg[4]=c, seg[3]=d, seg[2]=e, seg[1]=f, seg[0]=g
- dp  output  1  decimal point drive

Behaviour:
- Reset: while rst_n=0, asynchronously force seg and dp to the "off" level: 7'b0000000 and dp=0 when ACTIVE_LOW=0; 7'b1111111 and dp=1 when ACTIVE_LOW=1.
- Output updates only on a rising clk edge with en=1. With en=0, seg and dp hold.
- Latency is exactly 1 cycle from input to output.
- Active-high decode patterns, written abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- All 16 codes are decoded; there is no invalid-code state.
- dp (active-high) = dp_in.
- Control priority, highest first:
  1. lamp_test=1 → seg=1111111, dp=1.
  2. blank=1 → seg=0000000, dp=0.
  3. Otherwise → table decode of BCD, with dp=dp_in.
- When lamp_test and blank are both 1, lamp_test wins.
- ACTIVE_LOW=1 applies a bitwise inversion of seg and dp after priority resolution.
- Decode logic is purely combinational, feeding a single output register. No other state.
- Reset asserted mid-operation forces outputs off immediately.
- On reset release, outputs stay off until the first enabled clock edge.

Test Plan:
- Reset: rst_n=0 with BCD=8, lamp_test=1, no clock edge → seg=0000000, dp=0 immediately. Release; first enabled edge → seg=1111111.
- Full sweep: en=1, blank=0, lamp_test=0, BCD stepped 0..15, one per clock → each table pattern appears one cycle after its input. BCD=10 gives 1110111; BCD=15 gives 1000111.
- Enable hold: BCD=3 loaded (seg=1111001), then en=0 and BCD=7 → seg stays 1111001. Set en=1 → 1110000 on the next edge.
- Priority: BCD=2, dp_in=1:
  - blank=1 → seg=0000000, dp=0.
  - Add lamp_test=1 → seg=1111111, dp=1.
  - Clear both → seg=1101101, dp=1.
- ACTIVE_LOW=1 instance:
  - Reset → seg=1111111, dp=1.
  - BCD=1, dp_in=0 → seg=1001111, dp=1.
  - BCD=0xC → seg=0110001.
- Async reset mid-run: counting sequence running, pulse rst_n low between clock edges → outputs go to the off level without waiting for clk. Decoding resumes on the first enabled edge after release.
